gate_test_seq: RTL

- Exhaustive vector sequencer and checker for one 2-input switch-level CMOS gate under test (NOR, NAND, etc.).
- Drives the gate's two inputs through all four combinations and waits a programmable settle time after each.
- Samples the gate output and compares it against a parameterized truth table.
- Reports pass/fail, a per-vector fail mask and an error count. Sits in the gate-level testbench/lab harness between a test controller and the gate instance.

---
 rtl/gate_test_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/gate_test_seq.sv
// Sweeps a 2-input gate through all four input vectors, settling after each, and checks its output against TRUTH_TABLE.
// Optional build macro GTS_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module gate_test_seq #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [3:0]  TRUTH_TABLE   = 4'b0001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       dut_x,
    output logic       dut_y,
    input  logic       dut_a,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dut_x_q, dut_x_d;
    logic             dut_y_q, dut_y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [2:0]       err_count_q, err_count_d;
    logic [3:0]       fail_vec_q, fail_vec_d;
    logic             expected_a;
    logic             mismatch;

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        dut_x_d     = dut_x_q;
        dut_y_d     = dut_y_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        fail_vec_d  = fail_vec_q;
        expected_a  = TRUTH_TABLE[vec_q];
        // Case-inequality so a floating (X/Z) gate output is caught as a failure.
        mismatch    = (dut_a !== expected_a);

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d     = S_APPLY;
                    vec_d       = 2'd0;
                    err_count_d = 3'd0;
                    fail_vec_d  = 4'd0;
                    pass_d      = 1'b0;
                end
            end
            S_APPLY: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    dut_x_d = vec_q[1];
                    dut_y_d = vec_q[0];
                    cnt_d   = SETTLE_LOAD;
                    state_d = (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_SAMPLE;
                    end
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    if (mismatch) begin
                        err_count_d        = err_count_q + 3'd1;
                        fail_vec_d[vec_q]  = 1'b1;
                    end
`ifdef GTS_STOP_ON_FAIL_EN
                    if (mismatch || vec_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d   = vec_q + 2'd1;
                        state_d = S_APPLY;
                    end
`else
                    if (vec_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d   = vec_q + 2'd1;
                        state_d = S_APPLY;
                    end
`endif
                    // Verdict is latched on the way into DONE so it is valid alongside the done pulse.
                    if (state_d == S_DONE) begin
                        pass_d = (err_count_d == 3'd0);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        if (state_d == S_IDLE) begin
            dut_x_d = 1'b0;
            dut_y_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_q       <= 2'd0;
            cnt_q       <= '0;
            dut_x_q     <= 1'b0;
            dut_y_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 3'd0;
            fail_vec_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            dut_x_q     <= dut_x_d;
            dut_y_q     <= dut_y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            fail_vec_q  <= fail_vec_d;
        end
    end

    assign dut_x     = dut_x_q;
    assign dut_y     = dut_y_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign fail_vec  = fail_vec_q;

endmodule
